line_memory: RTL
================

LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 Parameter CACHE_LINE_SIZE, default 128, SHALL set the line width in bits (four 32-bit words).
REQ-002 Parameter MEMORY_ADDRESS_SIZE, default 32, SHALL set the byte-address width.
REQ-003 Parameter MEM_LINES, default 1024, SHALL set the number of stored lines (power of two).
REQ-004 Parameter MEM_LATENCY, default 5, SHALL set the cycles from accept to data_ready (legal range 1..255).
REQ-005 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 mem_enable  input  1  request valid from the cache.
REQ-008 mem_op  input  1  operation select: 0 = read line, 1 = write line.
REQ-009 mem_op_done  input  1  the cache has consumed the response and releases the memory.
REQ-010 mem_address  input  MEMORY_ADDRESS_SIZE  byte address; bits [3:0] are ignored.
REQ-011 mem_data_in  input  CACHE_LINE_SIZE  write line; word 0 occupies bits [31:0].
REQ-012 mem_data_out  output  CACHE_LINE_SIZE  read line, valid while mem_data_ready=1 after a read.
REQ-013 mem_data_ready  output  1  response ready: the read data is valid, or the write has completed.
REQ-014 memory_in_use  output  1  the memory is occupied from accept until release.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and READY.
REQ-016 IDLE with mem_enable=1: the block SHALL latch mem_op, mem_data_in and the line index, load the counter with MEM_LATENCY-1, and move to BUSY.
REQ-017 The line index SHALL be address[4+log2(MEM_LINES)-1:4]. Higher address bits SHALL be ignored, so addresses wrap modulo MEM_LINES lines.
REQ-018 BUSY SHALL decrement the counter each cycle. On the cycle after the counter reaches 0, the block SHALL perform the latched operation and move to READY. mem_data_ready SHALL therefore rise exactly MEM_LATENCY cycles after the accept edge.
REQ-019 A read SHALL load the stored line into mem_data_out. A write SHALL store the latched line, and mem_data_out SHALL hold its previous value.
REQ-020 READY SHALL hold mem_data_ready=1 and mem_data_out stable until mem_op_done=1 is sampled. The block SHALL then move to IDLE and clear mem_data_ready on that same edge.
REQ-021 memory_in_use SHALL be 1 in BUSY and READY, and 0 in IDLE.
REQ-022 mem_enable, mem_op, mem_address and mem_data_in changes SHALL be ignored outside IDLE; they SHALL NOT abort or alter an accepted request.
REQ-023 mem_op_done SHALL be ignored in IDLE and BUSY.
REQ-024 If mem_op_done=1 and mem_enable=1 are both sampled in READY, the block SHALL return to IDLE only. The new request SHALL be accepted no earlier than the following edge.
REQ-025 A read following a write to the same index SHALL return the written line (read-after-write).
REQ-026 Storage contents SHALL be undefined until written, unless preloaded by simulation initialisation.

Reset
REQ-027 On reset=0 the block SHALL asynchronously enter IDLE with mem_data_ready=0, memory_in_use=0, mem_data_out=0 and counter=0.
REQ-028 Reset asserted during BUSY or READY SHALL abandon the request. A write not yet performed SHALL NOT modify storage.
REQ-029 Storage contents SHALL NOT be cleared by reset.
REQ-030 The first request SHALL be accepted on the first rising edge with reset=1.

Structure
REQ-031 CACHE_LINE_SIZE, MEMORY_ADDRESS_SIZE, MEM_LINES, MEM_LATENCY and the state encodings SHALL live in the shared parameters file.
REQ-032 The latency countdown SHALL be a sub-module memory_latency_counter with load, enable and zero flag. The FSM and storage SHALL stay in line_memory.

Verification
REQ-033 Write then read: write 0x44444444_33333333_22222222_11111111 at 0x00000010, release, then read 0x0000001C. The read SHALL return the same line, with mem_data_ready exactly 5 cycles after each accept.
REQ-034 Hold and handshake: after a read, keep mem_op_done=0 for 10 cycles. mem_data_ready, memory_in_use and mem_data_out SHALL stay stable. Assert mem_op_done; all SHALL clear next edge.
REQ-035 Ignored inputs: change mem_address and mem_data_in and drop mem_enable during BUSY. The original request SHALL complete unchanged.
REQ-036 Simultaneous events: in READY, assert mem_op_done and mem_enable together. The block SHALL go IDLE, accept on the next edge, and mem_data_ready SHALL rise 5 cycles after that accept.
REQ-037 Reset mid-operation: assert reset 2 cycles into a write to index 3 of 0xAA..AA, over prior contents 0x55..55. Outputs SHALL clear immediately and a subsequent read of index 3 SHALL return 0x55..55.
REQ-038 Wrap-around: write at index MEM_LINES-1 (0x00003FF0), then read 0x00013FF0. The written line SHALL be returned.

Source files
------------

// File: rtl/line_memory_pkg.sv
// Shared parameters and state encodings for the line-granular backing memory.
// Every file of the memory slice imports this package.
package line_memory_pkg;

    localparam int DEF_CACHE_LINE_SIZE     = 128;
    localparam int DEF_MEMORY_ADDRESS_SIZE = 32;
    localparam int DEF_MEM_LINES           = 1024;
    localparam int DEF_MEM_LATENCY         = 5;

    // Wide enough for the largest legal latency (255).
    localparam int LAT_CNT_W = 8;

    // Byte offset inside a 16-byte line; these address bits never select a line.
    localparam int LINE_OFFSET_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        READY = 2'd2
    } mem_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

endpackage

// File: rtl/line_memory_if.sv
// Cache <-> memory request/response bundle. The cache side is the master;
// the memory side is the slave.
interface line_memory_if #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 32
) ();

    logic              mem_enable;
    logic              mem_op;
    logic              mem_op_done;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_data_in;
    logic [LINE_W-1:0] mem_data_out;
    logic              mem_data_ready;
    logic              memory_in_use;

    modport master (
        output mem_enable, mem_op, mem_op_done, mem_address, mem_data_in,
        input  mem_data_out, mem_data_ready, memory_in_use
    );

    modport slave (
        input  mem_enable, mem_op, mem_op_done, mem_address, mem_data_in,
        output mem_data_out, mem_data_ready, memory_in_use
    );

endinterface

// File: rtl/line_memory_latency_counter.sv
// Loadable down-counter that models the access latency; it stops at zero and
// flags when it gets there.
module memory_latency_counter
    import line_memory_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [LAT_CNT_W-1:0] load_value,
    input  logic                 enable,
    output logic [LAT_CNT_W-1:0] count,
    output logic                 zero
);

    assign zero = (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/line_memory.sv
// Line-wide memory with a fixed access latency. It serves one read or write
// per request and holds the response until the cache releases it.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int CACHE_LINE_SIZE     = DEF_CACHE_LINE_SIZE,
    parameter int MEMORY_ADDRESS_SIZE = DEF_MEMORY_ADDRESS_SIZE,
    parameter int MEM_LINES           = DEF_MEM_LINES,
    parameter int MEM_LATENCY         = DEF_MEM_LATENCY
) (
    input  logic          clk,
    input  logic          reset,
    line_memory_if.slave  bus
);

    localparam int IDX_W = $clog2(MEM_LINES);

    mem_state_t                 state;
    mem_op_t                    op_q;
    logic [IDX_W-1:0]           idx_q;
    logic [CACHE_LINE_SIZE-1:0] data_q;
    logic [CACHE_LINE_SIZE-1:0] data_out_q;
    logic                       ready_q;
    logic                       in_use_q;

    logic [CACHE_LINE_SIZE-1:0] storage [MEM_LINES];

    logic                       cnt_load;
    logic                       cnt_zero;
    logic [LAT_CNT_W-1:0]       cnt_value;
    logic                       wr_en;
    logic [IDX_W-1:0]           req_idx;
    logic                       unused_addr_bits;

    // Offset bits and bits above the line index are dropped, so lines wrap.
    assign req_idx          = bus.mem_address[LINE_OFFSET_W +: IDX_W];
    assign unused_addr_bits = ^{bus.mem_address[LINE_OFFSET_W-1:0],
                                bus.mem_address[MEMORY_ADDRESS_SIZE-1:LINE_OFFSET_W+IDX_W]};

    assign cnt_load = (state == IDLE) && bus.mem_enable;
    assign wr_en    = (state == BUSY) && cnt_zero && (op_q == OP_WRITE);

    memory_latency_counter u_latency (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (LAT_CNT_W'(MEM_LATENCY - 1)),
        .enable     (state == BUSY),
        .count      (cnt_value),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= OP_READ;
            idx_q      <= '0;
            data_q     <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            in_use_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_enable) begin
                        op_q     <= mem_op_t'(bus.mem_op);
                        idx_q    <= req_idx;
                        data_q   <= bus.mem_data_in;
                        in_use_q <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // The counter reached zero on the previous edge: serve now.
                    if (cnt_zero) begin
                        if (op_q == OP_READ) begin
                            data_out_q <= storage[idx_q];
                        end
                        ready_q <= 1'b1;
                        state   <= READY;
                    end
                end
                READY: begin
                    if (bus.mem_op_done) begin
                        ready_q  <= 1'b0;
                        in_use_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; clearing it would
    // prevent a RAM macro from being used and reset must leave contents intact.
    // A reset that arrives before the write edge forces the FSM back to IDLE,
    // so wr_en is already low and no write takes place.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            storage[idx_q] <= data_q;
        end
    end

    assign bus.mem_data_out   = data_out_q;
    assign bus.mem_data_ready = ready_q;
    assign bus.memory_in_use  = in_use_q;

endmodule
